gp_writeback_arbiter: RTL and testbench
=======================================

// Module: gp_writeback_arbiter
//
// PURPOSE
// - Collects result writes from NUM_SOURCES execution units and serialises them onto the
//   single GPR file write port, one write per cycle.
// - Each source has a one-entry holding buffer with a valid/ready handshake.
// - Holding buffers are drained in round-robin order.
// - Exports a pending-write mask so decode can stall on GPRs with writes still in flight.
//
// PARAMETERS
// - NUM_SOURCES  3  number of execution-unit result ports (2..8)
//
// PORTS
// - clk          in   1            clock, all state on rising edge
// - rst          in   1            asynchronous reset, active-low (0 = reset)
// - flush        in   1            synchronous; discards every buffered, not-yet-issued write
// - src_valid    in   [NUM_SOURCES]        source i presents a result
// - src_ready    out  [NUM_SOURCES]        buffer i can take a result this cycle
// - src_reg      in   [NUM_SOURCES][0:4]   target GPR of source i
// - src_data     in   [NUM_SOURCES][0:31]  result data of source i
// - write_enable out  1            GPR file write strobe
// - write_select out  [0:4]        GPR file write address
// - write_data   out  [0:31]       GPR file write data
// - pending_mask out  [0:31]       bit r = 1 while any buffer or output stage holds a write to GPR r
//
// BEHAVIOUR
// - Reset (rst=0, asynchronous):
//   - all buffers invalid; write_enable=0, write_select=0, write_data=0
//   - pending_mask=0; round-robin pointer=0
//   - src_ready all 0 while rst=0, all 1 from the first cycle after release.
// - Buffer i:
//   - src_ready[i] = !buf_valid[i] || grant[i]
//   - capture on the rising edge where src_valid[i] && src_ready[i]
//   - a granted buffer may be refilled on the same edge; full throughput is one result per source per cycle of grant.
// - Arbiter (combinational over buf_valid):
//   - search order is ptr, ptr+1, ..., wrapping modulo NUM_SOURCES
//   - the first valid buffer wins: grant one-hot, or all-zero if no buffer is valid
//   - on a grant, ptr <= winner+1 (mod NUM_SOURCES); otherwise ptr holds.
// - Output stage (registered):
//   - every edge: write_enable <= |grant, write_select/write_data <= winner's reg/data
//   - when there is no grant: write_enable <= 0, write_select/write_data hold their previous value.
// - Latency:
//   - result accepted at edge k, granted the following cycle, then write_enable=1 during cycle after edge k+1
//   - GPR updated at edge k+2; minimum 2 edges, uncontended.
// - Fairness: with all sources continuously valid, grants rotate 0,1,..,N-1,0; no source waits more than NUM_SOURCES-1 grants.
// - Ordering:
//   - a single source's writes retire in acceptance order
//   - writes from different sources to the same GPR follow grant order
//   - decode must use pending_mask to prevent conflicting in-flight targets.
// - pending_mask:
//   - OR over valid buffers of onehot(buf_reg), plus onehot(write_select) when write_enable=1
//   - combinational from state; excludes writes still on the src_* inputs.
// - flush:
//   - on the edge where flush=1, all buf_valid <= 0 and write_enable <= 0; inputs offered in that cycle are dropped
//   - ptr is unaffected
//   - a write already showing write_enable=1 during the flush cycle still completes at that edge.
// - Register 0 is not special; writes to r0 are issued like any other.
// - Every src_valid=1 and buf_valid=1 with equal target: no merging; both writes issue.
//
// TESTING
// - Single write:
//   - stimulus: src_valid[1]=1, reg=5, data=32'hDEADBEEF for one cycle
//   - expect: write_enable=1 with select=5 / data=DEADBEEF exactly 2 edges later
//   - expect: pending_mask[5]=1 from acceptance until the write completes.
// - Contention:
//   - stimulus: all 3 sources valid every cycle, regs 1/2/3
//   - expect: grants rotate 0,1,2,0,...; src_ready deasserts for losers; no write lost or duplicated over 30 cycles.
// - Back-to-back single source:
//   - stimulus: source 0 streams regs 7..14 with the other sources idle
//   - expect: one write per cycle, src_ready[0] stays 1, order preserved.
// - Flush:
//   - stimulus: fill all buffers, assert flush for 1 cycle
//   - expect: no further write_enable; pending_mask=0 on the next cycle; the in-flight output-stage write still lands.
// - Async reset mid-stream:
//   - stimulus: drop rst between clock edges while writes are pending
//   - expect: write_enable=0 and pending_mask=0 immediately, with no clock needed
//   - after release: first grant goes to source 0.

Source files
------------

// File: rtl/gp_writeback_arbiter.sv
// Write-back arbiter: one-entry holding buffer per execution unit, round-robin drain
// onto the single GPR write port, plus a mask of GPRs with writes still in flight.
module gp_writeback_arbiter #(
  parameter  int unsigned NUM_SOURCES = 3,
  localparam int unsigned REG_W       = 5,
  localparam int unsigned DATA_W      = 32,
  localparam int unsigned NUM_REGS    = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush_i,
  input  logic [NUM_SOURCES-1:0]              src_valid_i,
  output logic [NUM_SOURCES-1:0]              src_ready_o,
  input  logic [NUM_SOURCES-1:0][REG_W-1:0]   src_reg_i,
  input  logic [NUM_SOURCES-1:0][DATA_W-1:0]  src_data_i,
  output logic                                write_enable_o,
  output logic [REG_W-1:0]                    write_select_o,
  output logic [DATA_W-1:0]                   write_data_o,
  output logic [NUM_REGS-1:0]                 pending_mask_o
);

  localparam int unsigned PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int unsigned IDX_W = PTR_W + 1;

  logic [NUM_SOURCES-1:0]             buf_valid_q, buf_valid_d;
  logic [NUM_SOURCES-1:0][REG_W-1:0]  buf_reg_q,   buf_reg_d;
  logic [NUM_SOURCES-1:0][DATA_W-1:0] buf_data_q,  buf_data_d;
  logic [PTR_W-1:0]                   ptr_q,       ptr_d;
  logic                               we_q,        we_d;
  logic [REG_W-1:0]                   sel_q,       sel_d;
  logic [DATA_W-1:0]                  data_q,      data_d;

  logic [NUM_SOURCES-1:0] grant_c;
  logic [PTR_W-1:0]       win_c;
  logic                   any_c;
  logic [IDX_W-1:0]       idx_c;

  // Round-robin search starting at ptr; first valid buffer wins.
  always_comb begin
    grant_c = '0;
    win_c   = '0;
    any_c   = 1'b0;
    idx_c   = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      idx_c = IDX_W'(ptr_q) + IDX_W'(k);
      if (idx_c >= IDX_W'(NUM_SOURCES)) begin
        idx_c = idx_c - IDX_W'(NUM_SOURCES);
      end
      if (!any_c && buf_valid_q[idx_c[PTR_W-1:0]]) begin
        any_c                       = 1'b1;
        win_c                       = idx_c[PTR_W-1:0];
        grant_c[idx_c[PTR_W-1:0]]   = 1'b1;
      end
    end
  end

  // A granted buffer empties this edge, so it can be refilled at the same time.
  assign src_ready_o = rst_n ? (~buf_valid_q | grant_c) : '0;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_reg_d   = buf_reg_q;
    buf_data_d  = buf_data_q;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (grant_c[i]) begin
        buf_valid_d[i] = 1'b0;
      end
      if (src_valid_i[i] && src_ready_o[i]) begin
        buf_valid_d[i] = 1'b1;
        buf_reg_d[i]   = src_reg_i[i];
        buf_data_d[i]  = src_data_i[i];
      end
    end
    if (flush_i) begin
      buf_valid_d = '0;
    end
  end

  // Output stage and pointer advance; address/data hold when nothing issues.
  always_comb begin
    we_d   = any_c && !flush_i;
    sel_d  = sel_q;
    data_d = data_q;
    ptr_d  = ptr_q;
    if (we_d) begin
      sel_d  = buf_reg_q[win_c];
      data_d = buf_data_q[win_c];
    end
    if (any_c) begin
      ptr_d = (win_c == PTR_W'(NUM_SOURCES - 1)) ? '0 : win_c + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= '0;
      buf_reg_q   <= '0;
      buf_data_q  <= '0;
      ptr_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      data_q      <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_reg_q   <= buf_reg_d;
      buf_data_q  <= buf_data_d;
      ptr_q       <= ptr_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
    end
  end

  // In-flight targets: held buffers plus the write currently on the port.
  always_comb begin
    pending_mask_o = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (buf_valid_q[i]) begin
        pending_mask_o[buf_reg_q[i]] = 1'b1;
      end
    end
    if (we_q) begin
      pending_mask_o[sel_q] = 1'b1;
    end
  end

  assign write_enable_o = we_q;
  assign write_select_o = sel_q;
  assign write_data_o   = data_q;

endmodule

// File: tb/tb_gp_writeback_arbiter.sv
// Bench for gp_writeback_arbiter: cycle vectors for single/collision writes, then
// scoreboarded contention, streaming, flush and asynchronous reset sequences.
module tb_gp_writeback_arbiter;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [2:0]      src_valid;
  logic [2:0]      src_ready;
  logic [2:0][4:0] src_reg;
  logic [2:0][31:0] src_data;
  logic            we;
  logic [4:0]      sel;
  logic [31:0]     wdata;
  logic [31:0]     pend;

  int checks;
  int errors;
  int exp_src;
  int seq [3];
  logic [36:0] q0 [$];
  logic [36:0] q1 [$];
  logic [36:0] q2 [$];

  typedef struct packed {
    logic [2:0]       valid;
    logic [2:0][4:0]  regs;
    logic [2:0][31:0] data;
    logic             exp_we;
    logic [4:0]       exp_sel;
    logic [31:0]      exp_data;
    logic [31:0]      exp_pend;
    logic [2:0]       exp_rdy;
  } vec_t;

  vec_t tbl [10];

  gp_writeback_arbiter #(.NUM_SOURCES(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .src_valid_i    (src_valid),
    .src_ready_o    (src_ready),
    .src_reg_i      (src_reg),
    .src_data_i     (src_data),
    .write_enable_o (we),
    .write_select_o (sel),
    .write_data_o   (wdata),
    .pending_mask_o (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic ew, input logic [4:0] es,
                              input logic [31:0] ed, input logic [31:0] ep, input logic [2:0] er);
    vec_t t;
    t.valid    = v;
    t.regs     = {r2, r1, r0};
    t.data     = {d2, d1, d0};
    t.exp_we   = ew;
    t.exp_sel  = es;
    t.exp_data = ed;
    t.exp_pend = ep;
    t.exp_rdy  = er;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_all(input int base);
    for (int i = 0; i < 3; i++) begin
      src_valid[i] = 1'b1;
      src_reg[i]   = 5'(base + i);
      src_data[i]  = {4'(i), 28'(seq[i])};
    end
  endtask

  // Record every result the DUT will take at the coming edge.
  task automatic accept();
    for (int i = 0; i < 3; i++) begin
      if (src_valid[i] && src_ready[i]) begin
        case (i)
          0:       q0.push_back({src_reg[i], src_data[i]});
          1:       q1.push_back({src_reg[i], src_data[i]});
          default: q2.push_back({src_reg[i], src_data[i]});
        endcase
        seq[i]++;
      end
    end
  endtask

  task automatic check_write(input bit rot);
    logic [36:0] e;
    int s;
    int n;
    if (we) begin
      s = int'(wdata[31:28]);
      n = (s == 0) ? q0.size() : (s == 1) ? q1.size() : (s == 2) ? q2.size() : 0;
      checks++;
      if (n == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got write src %0d reg %0d data %h, expected none", s, sel, wdata);
      end else begin
        case (s)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        check("wb_sel", 32'(sel), 32'(e[36:32]));
        check("wb_data", wdata, e[31:0]);
        if (rot) begin
          check("rotation", 32'(s), 32'(exp_src));
          exp_src = (exp_src + 1) % 3;
        end
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_src = 0;
    seq     = '{0, 0, 0};

    tbl[0] = mk(3'b010, 5'd0, 5'd5, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0,
                1'b0, 5'd0, 32'd0, 32'h0000_0020, 3'b111);
    tbl[1] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
                1'b1, 5'd5, 32'hDEADBEEF, 32'h0000_0020, 3'b111);
    tbl[2] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
                1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 3'b111);
    tbl[3] = mk(3'b100, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h12345678,
                1'b0, 5'd5, 32'hDEADBEEF, 32'h0000_0001, 3'b111);
    tbl[4] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
                1'b1, 5'd0, 32'h12345678, 32'h0000_0001, 3'b111);
    tbl[5] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
                1'b0, 5'd0, 32'h12345678, 32'h0, 3'b111);
    tbl[6] = mk(3'b101, 5'd9, 5'd0, 5'd9, 32'h0000_000A, 32'd0, 32'h0000_000B,
                1'b0, 5'd0, 32'h12345678, 32'h0000_0200, 3'b011);
    tbl[7] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
                1'b1, 5'd9, 32'h0000_000A, 32'h0000_0200, 3'b111);
    tbl[8] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
                1'b1, 5'd9, 32'h0000_000B, 32'h0000_0200, 3'b111);
    tbl[9] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
                1'b0, 5'd9, 32'h0000_000B, 32'h0, 3'b111);

    rst_n     = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    src_reg   = '0;
    src_data  = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_we",    32'(we), 32'd0);
    check("reset_sel",   32'(sel), 32'd0);
    check("reset_data",  wdata, 32'd0);
    check("reset_pend",  pend, 32'd0);
    check("reset_ready", 32'(src_ready), 32'd0);
    #10 rst_n = 1'b1;
    #1;
    check("release_ready", 32'(src_ready), 32'h7);

    // Cycle-accurate vectors: outputs sampled just after each edge.
    for (int v = 0; v < 10; v++) begin
      src_valid = tbl[v].valid;
      src_reg   = tbl[v].regs;
      src_data  = tbl[v].data;
      tick();
      check($sformatf("vec%0d_we", v),    32'(we), 32'(tbl[v].exp_we));
      check($sformatf("vec%0d_sel", v),   32'(sel), 32'(tbl[v].exp_sel));
      check($sformatf("vec%0d_data", v),  wdata, tbl[v].exp_data);
      check($sformatf("vec%0d_pend", v),  pend, tbl[v].exp_pend);
      check($sformatf("vec%0d_ready", v), 32'(src_ready), 32'(tbl[v].exp_rdy));
    end

    // Contention: all sources valid every cycle for 30 cycles.
    for (int c = 0; c < 30; c++) begin
      drive_all(1);
      accept();
      tick();
      check_write(1'b1);
      check("contention_ready", 32'(src_ready), 32'(3'b001 << exp_src));
    end
    src_valid = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check_write(1'b0);
    end
    check("contention_left_s0", 32'(q0.size()), 32'd0);
    check("contention_left_s1", 32'(q1.size()), 32'd0);
    check("contention_left_s2", 32'(q2.size()), 32'd0);

    // Source 0 streams regs 7..14 alone.
    for (int c = 0; c < 8; c++) begin
      src_valid   = 3'b001;
      src_reg[0]  = 5'(7 + c);
      src_data[0] = {4'd0, 28'(seq[0])};
      check("b2b_ready0", 32'(src_ready[0]), 32'd1);
      accept();
      tick();
      if (c > 0) check("b2b_we", 32'(we), 32'd1);
      check_write(1'b0);
    end
    src_valid = '0;
    tick();
    check("b2b_last_we", 32'(we), 32'd1);
    check_write(1'b0);
    tick();
    check("b2b_idle_we", 32'(we), 32'd0);
    check("b2b_left_s0", 32'(q0.size()), 32'd0);

    // Flush with every buffer holding a write and one write on the port.
    drive_all(20);
    tick();
    src_valid = '0;
    tick();
    flush = 1'b1;
    drive_all(20);
    check("flush_inflight_we", 32'(we), 32'd1);
    check("flush_pend_busy", 32'(pend != 32'd0), 32'd1);
    tick();
    flush     = 1'b0;
    src_valid = '0;
    check("flush_we", 32'(we), 32'd0);
    check("flush_pend", pend, 32'd0);
    check("flush_ready", 32'(src_ready), 32'h7);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("flush_after_we", 32'(we), 32'd0);
      check("flush_after_pend", pend, 32'd0);
    end

    // Asynchronous reset between edges with writes outstanding.
    drive_all(24);
    tick();
    src_valid = '0;
    tick();
    check("rst_pre_we", 32'(we), 32'd1);
    check("rst_pre_pend", 32'(pend != 32'd0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_we",    32'(we), 32'd0);
    check("rst_mid_sel",   32'(sel), 32'd0);
    check("rst_mid_data",  wdata, 32'd0);
    check("rst_mid_pend",  pend, 32'd0);
    check("rst_mid_ready", 32'(src_ready), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("rst_rel_ready", 32'(src_ready), 32'h7);
    drive_all(27);
    tick();
    src_valid = '0;
    tick();
    check("rst_first_we",  32'(we), 32'd1);
    check("rst_first_sel", 32'(sel), 32'd27);
    check("rst_first_src", 32'(wdata[31:28]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
